board_move_arbiter: RTL and testbench
=====================================

// Module: board_move_arbiter
// PURPOSE
//  Parametrised successor to the 3x3 move-validation block: stores an N x N board of player IDs,
//  enforces turn order, validates each move request, commits it and scans all lines for a win or draw.
//  Sits between the input/FSM controller (move requests) and the display/score logic (results).
// PARAMETERS
//  BOARD_N    3   board side; cells = BOARD_N*BOARD_N; legal 3..8
//  PLAYERS    2   player count; IDs 1..PLAYERS, ID 0 = empty cell
//  TIMEOUT_CY 0   idle cycles before turn forfeit (used only with MOVE_TIMEOUT_EN; 0 = disabled)
//  Derived: PID_W=$clog2(PLAYERS+1), RC_W=$clog2(BOARD_N), CNT_W=$clog2(BOARD_N*BOARD_N+1)
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  new_game       in   1      synchronous board clear, lower priority than reset
//  move_valid     in   1      move request present
//  move_ready     out  1      block can accept a request (state IDLE)
//  move_player    in   PID_W  requesting player
//  move_row       in   RC_W   target row
//  move_col       in   RC_W   target column
//  move_accepted  out  1      1-cycle pulse: move committed
//  move_rejected  out  1      1-cycle pulse: move refused
//  reject_code    out  2      0 occupied, 1 out of range, 2 wrong turn, 3 game over; valid with move_rejected
//  turn_player    out  PID_W  player expected to move next
//  game_over      out  1      level: win or draw reached
//  winner         out  PID_W  winning ID; 0 while no win or on draw
//  draw           out  1      level: board full, no winner
//  query_row/col  in   RC_W   combinational cell read address
//  query_owner    out  PID_W  owner of queried cell (0 if out of range)
//  timeout        out  1      1-cycle pulse: turn forfeited (MOVE_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  Reset/new_game: all cells 0, turn_player=1, move count 0, game_over=draw=0, winner=0, all pulses 0,
//   state IDLE, move_ready=1. new_game mid-CHECK/EVAL aborts the scan, no result produced.
//  FSM: IDLE -> CHECK -> (IDLE | EVAL) -> IDLE.
//  IDLE: move_ready=1 (also when game_over). move_valid&&move_ready captures player/row/col -> CHECK.
//  CHECK (1 cycle, move_ready=0): first failing rule sets reject_code, in order: game_over(3),
//   row/col >= BOARD_N(1), move_player != turn_player(2), cell != 0(0); pulse move_rejected, -> IDLE.
//   Otherwise write cell, count++, pulse move_accepted, -> EVAL.
//  EVAL: line index 0..2*BOARD_N+1 (rows, columns, main diag, anti-diag), one line per cycle;
//   line wins if every cell == committing player. On first win: winner=player, game_over=1, -> IDLE
//   (early exit). After last line with no win: if count==BOARD_N^2 then draw=1, game_over=1;
//   else turn_player = (player==PLAYERS) ? 1 : player+1. -> IDLE.
//  Latency: accept/reject pulse 1 cycle after handshake; result worst case 2*BOARD_N+3 cycles after.
//  Simultaneous new_game and move_valid: new_game wins, request dropped, move_ready stays 1.
//  game_over, winner, draw hold until reset/new_game. turn_player frozen once game_over.
// CONFIGURATION
//  `MOVE_TIMEOUT_EN defined: cycle counter runs in IDLE while !game_over and TIMEOUT_CY>0; cleared
//   on handshake/new_game; reaching TIMEOUT_CY pulses timeout and advances turn_player (wraps to 1).
//  Not defined: no counter, timeout tied 0, turn advances only on accepted moves.
// STRUCTURE
//  Package board_pkg: state enum (IDLE, CHECK, EVAL), reject-code enum (RC_OCCUPIED,
//   RC_RANGE, RC_TURN, RC_OVER), EMPTY_ID=0 constant, line-index-to-cell helper function.
//  Sub-module board_cell_array: N*N PID_W registers, sync clear, one write port, two comb read
//   ports (query + line scan). FSM, turn and count logic stay in board_move_arbiter.
// TESTING (defaults N=3, P=2 unless stated)
//  1 Reset: all outputs at reset values; query any cell -> 0; turn_player=1.
//  2 P1 (0,0), P2 (1,1), P1 (0,1), P2 (2,2), P1 (0,2) -> five move_accepted; winner=1, game_over=1.
//  3 P1 (1,1) then P2 (1,1) -> reject_code 0; P2 again (1,1) -> 0; P1 (3,0) -> 1 before turn check.
//  4 P2 first move -> reject_code 2; after game_over any move -> reject_code 3; new_game clears all.
//  5 Nine-move draw sequence -> draw=1, winner=0, game_over=1; N=4,P=3 anti-diagonal win by P3.
//  6 new_game asserted during EVAL -> no winner/draw; MOVE_TIMEOUT_EN, TIMEOUT_CY=10: 10 idle
//    cycles -> timeout pulse, turn_player 1->2.

Source files
------------

// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Package   : board_pkg
// Purpose   : Shared types and helpers for the board move arbiter:
//             FSM state enum, reject-code enum, empty-cell ID and the
//             line-index-to-cell mapping used by the win scan.
// Revision  : 1.0  initial release
// ============================================================================
package board_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EVAL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RC_OCCUPIED = 2'd0,
        RC_RANGE    = 2'd1,
        RC_TURN     = 2'd2,
        RC_OVER     = 2'd3
    } reject_t;

    localparam int EMPTY_ID = 0;

    // Flat cell index (row*n + col) of the k-th cell of a scan line.
    // Lines 0..n-1 are rows, n..2n-1 columns, 2n the main diagonal and
    // 2n+1 the anti-diagonal.
    function automatic int line_cell(input int n, input int line, input int k);
        int idx;
        if (line < n) begin
            idx = line * n + k;
        end else if (line < 2 * n) begin
            idx = k * n + (line - n);
        end else if (line == 2 * n) begin
            idx = k * n + k;
        end else begin
            idx = k * n + (n - 1 - k);
        end
        return idx;
    endfunction

endpackage : board_pkg
`default_nettype wire

// File: rtl/board_cell_array.sv
`default_nettype none
// ============================================================================
// Module    : board_cell_array
// Purpose   : N x N storage of player IDs with synchronous clear, one write
//             port and two combinational read ports.
// Ports     : clock/reset     rising-edge clock, sync active-high reset
//             clear           sync clear of every cell (new game)
//             wr_en/row/col/data  single write port
//             query_row/col -> query_owner   cell read, 0 when out of range
//             line_idx -> line_owners        all N cells of one scan line,
//                                            cell k at [k*PID_W +: PID_W]
// Revision  : 1.0  initial release
// ============================================================================
module board_cell_array
    import board_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int PID_W   = 2,
    parameter int RC_W    = 2,
    parameter int LINE_W  = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [RC_W-1:0]            wr_row,
    input  logic [RC_W-1:0]            wr_col,
    input  logic [PID_W-1:0]           wr_data,
    input  logic [RC_W-1:0]            query_row,
    input  logic [RC_W-1:0]            query_col,
    output logic [PID_W-1:0]           query_owner,
    input  logic [LINE_W-1:0]          line_idx,
    output logic [BOARD_N*PID_W-1:0]   line_owners
);

    localparam int CELLS = BOARD_N * BOARD_N;

    logic [PID_W-1:0] cells_q [CELLS];
    logic [PID_W-1:0] cells_d [CELLS];

    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            cells_d[i] = cells_q[i];
            if (clear) begin
                cells_d[i] = PID_W'(EMPTY_ID);
            end else if (wr_en && (i == int'(wr_row) * BOARD_N + int'(wr_col))) begin
                cells_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < CELLS; i++) begin
            if (reset) begin
                cells_q[i] <= PID_W'(EMPTY_ID);
            end else begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

    // Address decode by comparison keeps every index a loop constant.
    always_comb begin
        query_owner = PID_W'(EMPTY_ID);
        if ((int'(query_row) < BOARD_N) && (int'(query_col) < BOARD_N)) begin
            for (int i = 0; i < CELLS; i++) begin
                if (i == int'(query_row) * BOARD_N + int'(query_col)) begin
                    query_owner = cells_q[i];
                end
            end
        end
    end

    always_comb begin
        line_owners = '0;
        for (int k = 0; k < BOARD_N; k++) begin
            for (int i = 0; i < CELLS; i++) begin
                if (i == line_cell(BOARD_N, int'(line_idx), k)) begin
                    line_owners[k*PID_W +: PID_W] = cells_q[i];
                end
            end
        end
    end

endmodule : board_cell_array
`default_nettype wire

// File: rtl/board_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : board_move_arbiter
// Purpose   : Holds an N x N board, enforces turn order, validates and
//             commits move requests, then scans every line for a win or a
//             draw (one line per cycle, early exit on the first win).
// Ports     : clock, reset (sync, active-high), new_game (sync clear)
//             move_valid/move_ready handshake with move_player/row/col
//             move_accepted, move_rejected + reject_code   1-cycle pulses
//             turn_player, game_over, winner, draw          game status
//             query_row/col -> query_owner                  comb cell read
//             timeout        1-cycle turn-forfeit pulse
// Options   : `MOVE_TIMEOUT_EN enables the idle-turn forfeit counter
//             (TIMEOUT_CY cycles); without it timeout is tied low.
// Revision  : 1.0  initial release
// ============================================================================
module board_move_arbiter
    import board_pkg::*;
#(
    parameter  int BOARD_N    = 3,
    parameter  int PLAYERS    = 2,
    parameter  int TIMEOUT_CY = 0,
    localparam int PID_W      = $clog2(PLAYERS + 1),
    localparam int RC_W       = $clog2(BOARD_N),
    localparam int CNT_W      = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_game,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [PID_W-1:0] move_player,
    input  logic [RC_W-1:0]  move_row,
    input  logic [RC_W-1:0]  move_col,
    output logic             move_accepted,
    output logic             move_rejected,
    output logic [1:0]       reject_code,
    output logic [PID_W-1:0] turn_player,
    output logic             game_over,
    output logic [PID_W-1:0] winner,
    output logic             draw,
    input  logic [RC_W-1:0]  query_row,
    input  logic [RC_W-1:0]  query_col,
    output logic [PID_W-1:0] query_owner,
    output logic             timeout
);

    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int NLINES = 2 * BOARD_N + 2;
    localparam int LINE_W = $clog2(NLINES);

    function automatic logic [PID_W-1:0] next_player(input logic [PID_W-1:0] p);
        return (int'(p) >= PLAYERS) ? PID_W'(1) : p + PID_W'(1);
    endfunction

    state_t                   state_q, state_d;
    logic [PID_W-1:0]         player_q, player_d;
    logic [RC_W-1:0]          row_q, row_d;
    logic [RC_W-1:0]          col_q, col_d;
    logic [PID_W-1:0]         turn_q, turn_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     game_over_q, game_over_d;
    logic [PID_W-1:0]         winner_q, winner_d;
    logic                     draw_q, draw_d;
    logic                     accepted_q, accepted_d;
    logic                     rejected_q, rejected_d;
    reject_t                  code_q, code_d;
    logic [LINE_W-1:0]        line_q, line_d;

    logic                     wr_en;
    logic [LINE_W-1:0]        scan_line;
    logic [BOARD_N*PID_W-1:0] line_owners;
    logic [PID_W-1:0]         target_owner;
    logic                     in_range;
    logic                     req_reject;
    reject_t                  req_code;
    logic                     line_win;

    board_cell_array #(
        .BOARD_N (BOARD_N),
        .PID_W   (PID_W),
        .RC_W    (RC_W),
        .LINE_W  (LINE_W)
    ) u_cells (
        .clock       (clock),
        .reset       (reset),
        .clear       (new_game),
        .wr_en       (wr_en),
        .wr_row      (row_q),
        .wr_col      (col_q),
        .wr_data     (player_q),
        .query_row   (query_row),
        .query_col   (query_col),
        .query_owner (query_owner),
        .line_idx    (scan_line),
        .line_owners (line_owners)
    );

    // While idle the scan port looks at the requested row, so the request
    // is classified on the handshake edge and the verdict is a registered
    // pulse during CHECK. In EVAL it walks the win lines.
    assign scan_line = (state_q == EVAL) ? line_q : LINE_W'(move_row);

    always_comb begin
        target_owner = PID_W'(EMPTY_ID);
        for (int k = 0; k < BOARD_N; k++) begin
            if (k == int'(move_col)) begin
                target_owner = line_owners[k*PID_W +: PID_W];
            end
        end
    end

    assign in_range = (int'(move_row) < BOARD_N) && (int'(move_col) < BOARD_N);

    // Rule order matters: the first failing rule names the reject code.
    always_comb begin
        req_reject = 1'b1;
        req_code   = RC_OCCUPIED;
        if (game_over_q) begin
            req_code = RC_OVER;
        end else if (!in_range) begin
            req_code = RC_RANGE;
        end else if (move_player != turn_q) begin
            req_code = RC_TURN;
        end else if (target_owner != PID_W'(EMPTY_ID)) begin
            req_code = RC_OCCUPIED;
        end else begin
            req_reject = 1'b0;
        end
    end

    always_comb begin
        line_win = 1'b1;
        for (int k = 0; k < BOARD_N; k++) begin
            if (line_owners[k*PID_W +: PID_W] != player_q) begin
                line_win = 1'b0;
            end
        end
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CY > 1) ? $clog2(TIMEOUT_CY + 1) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CY > 0);
`endif

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        row_d       = row_q;
        col_d       = col_q;
        turn_d      = turn_q;
        count_d     = count_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        draw_d      = draw_q;
        accepted_d  = 1'b0;
        rejected_d  = 1'b0;
        code_d      = code_q;
        line_d      = line_q;
        wr_en       = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = 1'b0;
`endif
        if (new_game) begin
            // Wins over a concurrent request and aborts any scan in flight.
            state_d     = IDLE;
            turn_d      = PID_W'(1);
            count_d     = '0;
            game_over_d = 1'b0;
            winner_d    = '0;
            draw_d      = 1'b0;
            code_d      = RC_OCCUPIED;
            line_d      = '0;
`ifdef MOVE_TIMEOUT_EN
            to_cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (move_valid) begin
                        player_d   = move_player;
                        row_d      = move_row;
                        col_d      = move_col;
                        accepted_d = !req_reject;
                        rejected_d = req_reject;
                        code_d     = req_reject ? req_code : code_q;
                        state_d    = CHECK;
                    end
                end
                CHECK: begin
                    if (accepted_q) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        line_d  = '0;
                        state_d = EVAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EVAL: begin
                    if (line_win) begin
                        winner_d    = player_q;
                        game_over_d = 1'b1;
                        state_d     = IDLE;
                    end else if (line_q == LINE_W'(NLINES - 1)) begin
                        if (count_q == CNT_W'(CELLS)) begin
                            draw_d      = 1'b1;
                            game_over_d = 1'b1;
                        end else begin
                            turn_d = next_player(player_q);
                        end
                        state_d = IDLE;
                    end else begin
                        line_d = line_q + LINE_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
`ifdef MOVE_TIMEOUT_EN
            if (state_q == IDLE) begin
                if (move_valid) begin
                    to_cnt_d = '0;
                end else if (!game_over_q && (TIMEOUT_CY > 0)) begin
                    if (int'(to_cnt_q) == TIMEOUT_CY - 1) begin
                        to_cnt_d  = '0;
                        timeout_d = 1'b1;
                        turn_d    = next_player(turn_q);
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            player_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            turn_q      <= PID_W'(1);
            count_q     <= '0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
            draw_q      <= 1'b0;
            accepted_q  <= 1'b0;
            rejected_q  <= 1'b0;
            code_q      <= RC_OCCUPIED;
            line_q      <= '0;
`ifdef MOVE_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            row_q       <= row_d;
            col_q       <= col_d;
            turn_q      <= turn_d;
            count_q     <= count_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
            accepted_q  <= accepted_d;
            rejected_q  <= rejected_d;
            code_q      <= code_d;
            line_q      <= line_d;
`ifdef MOVE_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign move_ready    = (state_q == IDLE);
    assign move_accepted = accepted_q;
    assign move_rejected = rejected_q;
    assign reject_code   = code_q;
    assign turn_player   = turn_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign draw          = draw_q;
`ifdef MOVE_TIMEOUT_EN
    assign timeout       = timeout_q;
`else
    assign timeout       = 1'b0;
`endif

endmodule : board_move_arbiter
`default_nettype wire

// File: tb/tb_board_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_board_move_arbiter
// Purpose   : Self-checking bench for board_move_arbiter (N=3,P=2 main
//             instance plus an N=4,P=3 instance for the anti-diagonal win).
// Revision  : 1.0  initial release
// ============================================================================
module tb_board_move_arbiter;

    localparam int N = 3;
    localparam int P = 2;

    logic       clock = 1'b0;
    logic       reset, new_game, move_valid;
    logic [1:0] move_player, move_row, move_col, query_row, query_col;
    logic       move_ready, move_accepted, move_rejected, game_over, draw, timeout;
    logic [1:0] reject_code, turn_player, winner, query_owner;

    logic       n4_new_game, n4_valid, n4_ready, n4_acc, n4_rej, n4_over, n4_draw, n4_timeout;
    logic [1:0] n4_player, n4_row, n4_col, n4_qrow, n4_qcol;
    logic [1:0] n4_code, n4_turn, n4_winner, n4_qowner;

    always #5 clock = ~clock;

    board_move_arbiter #(
        .BOARD_N (N),
        .PLAYERS (P),
`ifdef MOVE_TIMEOUT_EN
        .TIMEOUT_CY (10)
`else
        .TIMEOUT_CY (0)
`endif
    ) dut (
        .clock (clock), .reset (reset), .new_game (new_game),
        .move_valid (move_valid), .move_ready (move_ready),
        .move_player (move_player), .move_row (move_row), .move_col (move_col),
        .move_accepted (move_accepted), .move_rejected (move_rejected),
        .reject_code (reject_code), .turn_player (turn_player),
        .game_over (game_over), .winner (winner), .draw (draw),
        .query_row (query_row), .query_col (query_col),
        .query_owner (query_owner), .timeout (timeout)
    );

    board_move_arbiter #(.BOARD_N (4), .PLAYERS (3), .TIMEOUT_CY (0)) dut4 (
        .clock (clock), .reset (reset), .new_game (n4_new_game),
        .move_valid (n4_valid), .move_ready (n4_ready),
        .move_player (n4_player), .move_row (n4_row), .move_col (n4_col),
        .move_accepted (n4_acc), .move_rejected (n4_rej),
        .reject_code (n4_code), .turn_player (n4_turn),
        .game_over (n4_over), .winner (n4_winner), .draw (n4_draw),
        .query_row (n4_qrow), .query_col (n4_qcol),
        .query_owner (n4_qowner), .timeout (n4_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the N=3 game ----------------
    int bd [0:N-1][0:N-1];
    int m_turn, m_cnt, m_over, m_win, m_draw;
    bit sync;

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bd[r][c] = 0;
        m_turn = 1; m_cnt = 0; m_over = 0; m_win = 0; m_draw = 0;
    endtask

    // -1 = accepted, otherwise the reject code
    function automatic int model_code(input int p, input int r, input int c);
        if (m_over != 0) return 3;
        if (r >= N || c >= N) return 1;
        if (p != m_turn) return 2;
        if (bd[r][c] != 0) return 0;
        return -1;
    endfunction

    task automatic model_commit(input int p, input int r, input int c);
        int won, d1, d2, rc, cc;
        bd[r][c] = p;
        m_cnt++;
        won = 0; d1 = 0; d2 = 0;
        for (int i = 0; i < N; i++) begin
            rc = 0; cc = 0;
            for (int j = 0; j < N; j++) begin
                if (bd[i][j] == p) rc++;
                if (bd[j][i] == p) cc++;
            end
            if (rc == N || cc == N) won = 1;
            if (bd[i][i] == p) d1++;
            if (bd[i][N-1-i] == p) d2++;
        end
        if (d1 == N || d2 == N) won = 1;
        if (won != 0) begin
            m_win = p; m_over = 1;
        end else if (m_cnt == N * N) begin
            m_draw = 1; m_over = 1;
        end else begin
            m_turn = (p == P) ? 1 : p + 1;
        end
    endtask

    // ---------------- per-cycle compare while idle ----------------
    int qi = 0;
    always @(negedge clock) begin
        int qr, qc, exp_own;
        if (sync) begin
            qr = qi / 4;
            qc = qi % 4;
            qi = (qi + 1) % 16;
            query_row = 2'(qr);
            query_col = 2'(qc);
            #1;
            exp_own = (qr < N && qc < N) ? bd[qr][qc] : 0;
            check("idle_query_owner", int'(query_owner), exp_own);
            check("idle_move_ready", int'(move_ready), 1);
            check("idle_turn_player", int'(turn_player), m_turn);
            check("idle_game_over", int'(game_over), m_over);
            check("idle_winner", int'(winner), m_win);
            check("idle_draw", int'(draw), m_draw);
            check("idle_pulses", int'({move_accepted, move_rejected}), 0);
`ifndef MOVE_TIMEOUT_EN
            check("idle_timeout", int'(timeout), 0);
`endif
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!move_ready && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
        check({"ready_", tag}, int'(move_ready), 1);
    endtask

    task automatic do_move(input int p, input int r, input int c, input int lit, input string tag);
        int mc;
        mc = model_code(p, r, c);
        check({"model_", tag}, mc, lit);
        sync = 1'b0;
        move_valid = 1'b1;
        move_player = 2'(p); move_row = 2'(r); move_col = 2'(c);
        @(posedge clock); #1;
        move_valid = 1'b0;
        check({"accepted_", tag}, int'(move_accepted), (lit == -1) ? 1 : 0);
        check({"rejected_", tag}, int'(move_rejected), (lit == -1) ? 0 : 1);
        if (lit != -1) check({"code_", tag}, int'(reject_code), lit);
        wait_ready(tag);
        if (lit == -1) model_commit(p, r, c);
        sync = 1'b1;
    endtask

    task automatic do_new_game();
        sync = 1'b0;
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        model_reset();
        sync = 1'b1;
    endtask

    task automatic mv4(input int p, input int r, input int c, input string tag);
        int k;
        n4_valid = 1'b1;
        n4_player = 2'(p); n4_row = 2'(r); n4_col = 2'(c);
        @(posedge clock); #1;
        n4_valid = 1'b0;
        check({"n4_accepted_", tag}, int'(n4_acc), 1);
        k = 0;
        while (!n4_ready && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
        check({"n4_ready_", tag}, int'(n4_ready), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0;
        move_player = '0; move_row = '0; move_col = '0;
        query_row = '0; query_col = '0;
        n4_new_game = 1'b0; n4_valid = 1'b0; n4_player = '0; n4_row = '0; n4_col = '0;
        n4_qrow = '0; n4_qcol = '0;
        sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state, hand values
        query_row = 2'd2; query_col = 2'd2;
        #1;
        check("rst_ready", int'(move_ready), 1);
        check("rst_turn", int'(turn_player), 1);
        check("rst_over", int'({game_over, draw}), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_pulses", int'({move_accepted, move_rejected, timeout}), 0);
        check("rst_query", int'(query_owner), 0);
        @(posedge clock); #1;
        sync = 1'b1;

        // Row-0 win by player 1
        do_move(1, 0, 0, -1, "w1");
        do_move(2, 1, 1, -1, "w2");
        do_move(1, 0, 1, -1, "w3");
        do_move(2, 2, 2, -1, "w4");
        do_move(1, 0, 2, -1, "w5");
        check("win_winner_lit", int'(winner), 1);
        check("win_over_lit", int'(game_over), 1);
        check("win_draw_lit", int'(draw), 0);
        do_move(2, 2, 0, 3, "after_over");
        do_move(1, 3, 3, 3, "over_beats_range");
        repeat (2) @(posedge clock); #1;
        do_new_game();
        repeat (2) @(posedge clock); #1;

        // Occupied and range rejections
        do_move(1, 1, 1, -1, "o1");
        do_move(2, 1, 1, 0, "occ_a");
        do_move(2, 1, 1, 0, "occ_b");
        do_move(1, 3, 0, 1, "range_before_turn");
        do_move(2, 0, 3, 1, "range_col");
        do_new_game();

        // Wrong turn, then a draw
        do_move(2, 0, 0, 2, "p2_first");
        do_move(1, 0, 0, -1, "d1");
        do_move(2, 0, 1, -1, "d2");
        do_move(1, 0, 2, -1, "d3");
        do_move(2, 1, 1, -1, "d4");
        do_move(1, 1, 0, -1, "d5");
        do_move(2, 1, 2, -1, "d6");
        do_move(1, 2, 1, -1, "d7");
        do_move(2, 2, 0, -1, "d8");
        do_move(1, 2, 2, -1, "d9");
        check("draw_lit", int'(draw), 1);
        check("draw_winner_lit", int'(winner), 0);
        check("draw_over_lit", int'(game_over), 1);
        repeat (2) @(posedge clock); #1;

        // new_game together with a request: request is dropped
        sync = 1'b0;
        new_game = 1'b1; move_valid = 1'b1;
        move_player = 2'd1; move_row = 2'd0; move_col = 2'd0;
        @(posedge clock); #1;
        new_game = 1'b0; move_valid = 1'b0;
        check("ng_req_ready", int'(move_ready), 1);
        check("ng_req_pulses", int'({move_accepted, move_rejected}), 0);
        model_reset();
        sync = 1'b1;
        repeat (3) @(posedge clock); #1;

        // new_game during EVAL of a winning column-2 move
        do_move(1, 0, 2, -1, "e1");
        do_move(2, 0, 0, -1, "e2");
        do_move(1, 1, 2, -1, "e3");
        do_move(2, 1, 0, -1, "e4");
        sync = 1'b0;
        move_valid = 1'b1; move_player = 2'd1; move_row = 2'd2; move_col = 2'd2;
        @(posedge clock); #1;
        move_valid = 1'b0;
        check("eval_abort_accepted", int'(move_accepted), 1);
        @(posedge clock); #1;
        check("eval_abort_busy", int'(move_ready), 0);
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        check("eval_abort_over", int'(game_over), 0);
        check("eval_abort_winner", int'(winner), 0);
        check("eval_abort_turn", int'(turn_player), 1);
        model_reset();
        sync = 1'b1;
`ifndef MOVE_TIMEOUT_EN
        repeat (9) @(posedge clock); #1;
`else
        repeat (2) @(posedge clock); #1;
`endif

        // N=4, P=3: anti-diagonal win by player 3
        mv4(1, 0, 0, "a1"); mv4(2, 0, 1, "a2"); mv4(3, 0, 3, "a3");
        mv4(1, 1, 0, "b1"); mv4(2, 1, 1, "b2"); mv4(3, 1, 2, "b3");
        check("n4_turn_mid", int'(n4_turn), 1);
        check("n4_over_mid", int'(n4_over), 0);
        mv4(1, 2, 3, "c1"); mv4(2, 3, 3, "c2"); mv4(3, 2, 1, "c3");
        mv4(1, 3, 1, "d1"); mv4(2, 3, 2, "d2"); mv4(3, 3, 0, "d3");
        n4_qrow = 2'd3; n4_qcol = 2'd0;
        #1;
        check("n4_winner", int'(n4_winner), 3);
        check("n4_over", int'(n4_over), 1);
        check("n4_draw", int'(n4_draw), 0);
        check("n4_query_30", int'(n4_qowner), 3);

`ifdef MOVE_TIMEOUT_EN
        // Idle forfeit after 10 cycles
        do_new_game();
        sync = 1'b0;
        k = 0;
        while (!timeout && k < 30) begin
            @(posedge clock); #1;
            k++;
        end
        check("timeout_cycles", k, 10);
        check("timeout_turn", int'(turn_player), 2);
        @(posedge clock); #1;
        check("timeout_pulse_len", int'(timeout), 0);
`endif

        sync = 1'b0;
        @(posedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_board_move_arbiter
`default_nettype wire
